// File: rtl/hw_ctrl_seq.sv
// Hardwired controller for the teaching CPU: beat generator, console mode latch,
// multi-register console transfers and a single-level interrupt handshake.
module hw_ctrl_seq #(
    parameter int RSEL_W = 2,
    parameter bit INT_EN = 1'b1
) (
    input  logic                  T3,
    input  logic                  CLR,
    input  logic [2:0]            SW,
    input  logic [3:0]            IR,
    input  logic                  C,
    input  logic                  Z,
    input  logic                  INTR,
    output logic [2:0]            W,
    output logic                  ST0,
    output logic                  DRW,
    output logic                  LPC,
    output logic                  PCINC,
    output logic                  PCADD,
    output logic                  LAR,
    output logic                  ARINC,
    output logic                  LIR,
    output logic                  LDZ,
    output logic                  LDC,
    output logic                  CIN,
    output logic                  M,
    output logic                  MEMW,
    output logic                  ABUS,
    output logic                  SBUS,
    output logic                  MBUS,
    output logic                  SELCTL,
    output logic                  STOP,
    output logic [3:0]            S,
    output logic [2*RSEL_W-1:0]   SEL,
    output logic                  INTA,
    output logic                  LVEC
);

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_e;

    localparam logic [2:0] MODE_FETCH = 3'b000;
    localparam logic [2:0] MODE_WMEM  = 3'b001;
    localparam logic [2:0] MODE_RMEM  = 3'b010;
    localparam logic [2:0] MODE_RREG  = 3'b011;
    localparam logic [2:0] MODE_WREG  = 3'b100;

    localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100, OP_LD  = 4'b0101, OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111, OP_JZ  = 4'b1000, OP_JMP = 4'b1001;
    localparam logic [3:0] OP_OR  = 4'b1010, OP_CMP = 4'b1011, OP_MOV = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101, OP_STP = 4'b1110, OP_EI  = 4'b1111;

    beat_e             beat;
    beat_e             beat_nxt;
    logic [2:0]        mode;
    logic              mode_vld;
    logic              ien;
    logic              intp;
    logic              halt;
    logic [RSEL_W-1:0] rc;
    logic [RSEL_W-1:0] rc_p1;
    logic              short_beat;
    logic              long_beat;
    logic              exec_ok;
    logic              stp_beat;
    logic              ei_beat;
    logic              last_beat;

    assign W     = beat;
    assign rc_p1 = rc + RSEL_W'(1);

    assign exec_ok   = mode_vld && !halt && (mode == MODE_FETCH) && ST0;
    assign stp_beat  = exec_ok && (beat == BEAT_W2) && (IR == OP_STP);
    assign ei_beat   = INT_EN && exec_ok && (beat == BEAT_W2) && (IR == OP_EI);
    assign last_beat = exec_ok && (((beat == BEAT_W2) && !long_beat) || (beat == BEAT_W3));

    // Strobe decode from the registered beat/phase/mode state
    always_comb begin
        {DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC} = '0;
        {CIN, M, MEMW, ABUS, SBUS, MBUS, SELCTL}            = '0;
        STOP       = 1'b0;
        S          = 4'b1111;
        SEL        = '0;
        INTA       = 1'b0;
        LVEC       = 1'b0;
        short_beat = 1'b0;
        long_beat  = 1'b0;
        if (!mode_vld) begin
            STOP = 1'b1;
            S    = 4'b0000;
        end else if (halt) begin
            STOP = 1'b1;
        end else begin
            case (mode)
                MODE_FETCH: begin
                    case (beat)
                        BEAT_W1: begin
                            if (INT_EN && intp) begin
                                INTA = 1'b1; LVEC = 1'b1; short_beat = 1'b1;
                            end else if (!ST0) begin
                                LPC = 1'b1; SBUS = 1'b1; short_beat = 1'b1;
                            end else begin
                                LIR = 1'b1; PCINC = 1'b1;
                            end
                        end
                        BEAT_W2: begin
                            case (IR)
                                OP_ADD: begin S = 4'b1001; CIN = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1; end
                                OP_SUB: begin S = 4'b0110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1; end
                                OP_AND: begin S = 4'b1011; M = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; end
                                OP_INC: begin S = 4'b0000; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1; end
                                OP_LD:  begin S = 4'b1010; M = 1'b1; ABUS = 1'b1; LAR = 1'b1; long_beat = 1'b1; end
                                OP_ST:  begin S = 4'b1111; M = 1'b1; ABUS = 1'b1; LAR = 1'b1; long_beat = 1'b1; end
                                OP_JC:  PCADD = C;
                                OP_JZ:  PCADD = Z;
                                OP_JMP: begin S = 4'b1111; M = 1'b1; ABUS = 1'b1; LPC = 1'b1; end
                                OP_OR:  begin S = 4'b1110; M = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; end
                                OP_CMP: begin S = 4'b0110; LDZ = 1'b1; LDC = 1'b1; end
                                OP_MOV: begin S = 4'b1010; M = 1'b1; ABUS = 1'b1; DRW = 1'b1; end
                                OP_OUT: begin S = 4'b1010; M = 1'b1; ABUS = 1'b1; end
                                OP_STP: STOP = 1'b1;
                                default: ;
                            endcase
                        end
                        BEAT_W3: begin
                            case (IR)
                                OP_LD:   begin MBUS = 1'b1; DRW = 1'b1; end
                                OP_ST:   begin S = 4'b1010; M = 1'b1; ABUS = 1'b1; MEMW = 1'b1; end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                MODE_WMEM: begin
                    SELCTL = 1'b1; STOP = 1'b1; short_beat = 1'b1; SBUS = 1'b1;
                    if (!ST0) LAR = 1'b1;
                    else begin MEMW = 1'b1; ARINC = 1'b1; end
                end
                MODE_RMEM: begin
                    SELCTL = 1'b1; STOP = 1'b1; short_beat = 1'b1;
                    if (!ST0) begin LAR = 1'b1; SBUS = 1'b1; end
                    else begin MBUS = 1'b1; ARINC = 1'b1; end
                end
                MODE_WREG: begin
                    SELCTL = 1'b1; STOP = 1'b1; short_beat = 1'b1;
                    SBUS = 1'b1; DRW = 1'b1; SEL = {rc, rc};
                end
                MODE_RREG: begin
                    SELCTL = 1'b1; STOP = 1'b1; short_beat = 1'b1;
                    SEL = {rc, rc_p1};
                end
                default: begin
                    SELCTL = 1'b1; STOP = 1'b1; short_beat = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        case (beat)
            BEAT_W1: beat_nxt = short_beat ? BEAT_W1 : BEAT_W2;
            BEAT_W2: beat_nxt = long_beat ? BEAT_W3 : BEAT_W1;
            default: beat_nxt = BEAT_W1;
        endcase
    end

    // Sequencer state: the first edge after reset only latches the console mode
    always_ff @(posedge T3 or posedge CLR) begin
        if (CLR) begin
            beat     <= BEAT_W1;
            ST0      <= 1'b0;
            mode     <= MODE_FETCH;
            mode_vld <= 1'b0;
            ien      <= 1'b0;
            intp     <= 1'b0;
            halt     <= 1'b0;
            rc       <= '0;
        end else if (!mode_vld) begin
            mode     <= SW;
            mode_vld <= 1'b1;
        end else if (!halt) begin
            if (stp_beat) begin
                halt <= 1'b1;
                intp <= 1'b0;
            end else begin
                beat <= beat_nxt;
                case (mode)
                    MODE_FETCH: begin
                        if (beat == BEAT_W1 && !ST0) ST0 <= 1'b1;
                        if (beat == BEAT_W1 && intp) begin
                            intp <= 1'b0;
                            ien  <= 1'b0;
                        end
                        if (ei_beat) ien <= 1'b1;
                        // EI itself never opens the window; its successor must complete first
                        if (INT_EN && last_beat && ien && INTR && (IR != OP_EI)) intp <= 1'b1;
                    end
                    MODE_WMEM, MODE_RMEM: if (!ST0) ST0 <= 1'b1;
                    MODE_WREG: rc <= rc_p1;
                    MODE_RREG: rc <= rc + RSEL_W'(2);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// Self-checking bench for hw_ctrl_seq: instruction trace table plus console,
// reset and interrupt sequences, compared through an expected-value queue.
module tb_hw_ctrl_seq;

    logic       T3, CLR, C, Z, INTR;
    logic [2:0] SW;
    logic [3:0] IR;
    logic [2:0] W;
    logic       ST0, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC;
    logic       CIN, M, MEMW, ABUS, SBUS, MBUS, SELCTL, STOP, INTA, LVEC;
    logic [3:0] S;
    logic [3:0] SEL;

    hw_ctrl_seq #(.RSEL_W(2), .INT_EN(1'b1)) dut (
        .T3(T3), .CLR(CLR), .SW(SW), .IR(IR), .C(C), .Z(Z), .INTR(INTR),
        .W(W), .ST0(ST0), .DRW(DRW), .LPC(LPC), .PCINC(PCINC), .PCADD(PCADD),
        .LAR(LAR), .ARINC(ARINC), .LIR(LIR), .LDZ(LDZ), .LDC(LDC), .CIN(CIN),
        .M(M), .MEMW(MEMW), .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS), .SELCTL(SELCTL),
        .STOP(STOP), .S(S), .SEL(SEL), .INTA(INTA), .LVEC(LVEC)
    );

    initial T3 = 1'b0;
    always #5 T3 = ~T3;

    localparam logic [15:0] B_DRW = 16'h8000, B_LPC = 16'h4000, B_PCINC = 16'h2000, B_PCADD = 16'h1000;
    localparam logic [15:0] B_LAR = 16'h0800, B_ARINC = 16'h0400, B_LIR = 16'h0200, B_LDZ = 16'h0100;
    localparam logic [15:0] B_LDC = 16'h0080, B_CIN = 16'h0040, B_M = 16'h0020, B_MEMW = 16'h0010;
    localparam logic [15:0] B_ABUS = 16'h0008, B_SBUS = 16'h0004, B_MBUS = 16'h0002, B_SELCTL = 16'h0001;

    typedef struct {
        string      name;
        logic [2:0] sw;
        logic [3:0] ir;
        logic       c, z, intr;
        logic [2:0] w;
        logic       st0;
        logic [15:0] strb;
        logic       stop;
        logic [3:0] s;
        logic [3:0] sel;
        logic       inta, lvec;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    wire [15:0] act_strb = {DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
                            CIN, M, MEMW, ABUS, SBUS, MBUS, SELCTL};

    function automatic vec_t mk(string n, logic [2:0] sw, logic [3:0] ir, logic c, logic z,
                                logic intr, logic [2:0] w, logic st0, logic [15:0] strb,
                                logic stop, logic [3:0] s, logic [3:0] sel, logic inta, logic lvec);
        vec_t v;
        v.name = n; v.sw = sw; v.ir = ir; v.c = c; v.z = z; v.intr = intr;
        v.w = w; v.st0 = st0; v.strb = strb; v.stop = stop; v.s = s; v.sel = sel;
        v.inta = inta; v.lvec = lvec;
        return v;
    endfunction

    function automatic vec_t fe(string n, logic [3:0] ir, logic c, logic z, logic intr,
                                logic [2:0] w, logic [15:0] strb, logic [3:0] s);
        return mk(n, 3'b000, ir, c, z, intr, w, 1'b1, strb, 1'b0, s, 4'h0, 1'b0, 1'b0);
    endfunction

    function automatic vec_t w1v(logic intr);
        return fe("fetch_w1", 4'h0, 1'b0, 1'b0, intr, 3'b001, B_LIR | B_PCINC, 4'hF);
    endfunction

    function automatic vec_t rstv(logic [2:0] sw, logic [3:0] ir);
        return mk("reset_state", sw, ir, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    endfunction

    task automatic check_pop();
        vec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got no expected record, required one");
        end else begin
            e = exp_q.pop_front();
            if (W !== e.w || ST0 !== e.st0 || act_strb !== e.strb || STOP !== e.stop ||
                S !== e.s || SEL !== e.sel || INTA !== e.inta || LVEC !== e.lvec) begin
                failures++;
                $display("FAIL %s @%0t: got w=%b st0=%b strb=%h stop=%b s=%h sel=%h inta=%b lvec=%b; required w=%b st0=%b strb=%h stop=%b s=%h sel=%h inta=%b lvec=%b",
                         e.name, $time, W, ST0, act_strb, STOP, S, SEL, INTA, LVEC,
                         e.w, e.st0, e.strb, e.stop, e.s, e.sel, e.inta, e.lvec);
            end
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one
    task automatic apply(input vec_t v);
        SW = v.sw; IR = v.ir; C = v.c; Z = v.z; INTR = v.intr;
        exp_q.push_back(v);
        @(negedge T3);
        check_pop();
        @(posedge T3);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] sw);
        CLR = 1'b1; SW = sw; IR = 4'h0; C = 1'b0; Z = 1'b0; INTR = 1'b0;
        exp_q.push_back(rstv(sw, 4'h0));
        @(negedge T3);
        check_pop();
        @(posedge T3);
        #1;
        CLR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CLR = 1'b1; SW = 3'b000; IR = 4'h0; C = 1'b0; Z = 1'b0; INTR = 1'b0;
        @(posedge T3);
        #1;

        // Fetch/execute trace from reset
        tbl.push_back(rstv(3'b000, 4'h0));
        tbl.push_back(mk("fetch_st0", 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_LPC | B_SBUS, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("add_w2", 4'h1, 1'b0, 1'b0, 1'b0, 3'b010, B_DRW | B_LDZ | B_LDC | B_CIN | B_ABUS, 4'h9));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("st_w2", 4'h6, 1'b0, 1'b0, 1'b0, 3'b010, B_LAR | B_M | B_ABUS, 4'hF));
        tbl.push_back(fe("st_w3", 4'h6, 1'b0, 1'b0, 1'b0, 3'b100, B_M | B_ABUS | B_MEMW, 4'hA));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("jc_c0", 4'h7, 1'b0, 1'b0, 1'b0, 3'b010, 16'h0, 4'hF));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("jc_c1", 4'h7, 1'b1, 1'b0, 1'b0, 3'b010, B_PCADD, 4'hF));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("sub_w2", 4'h2, 1'b0, 1'b0, 1'b0, 3'b010, B_DRW | B_LDZ | B_LDC | B_ABUS, 4'h6));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("cmp_w2", 4'hB, 1'b0, 1'b0, 1'b0, 3'b010, B_LDZ | B_LDC, 4'h6));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("ld_w2", 4'h5, 1'b0, 1'b0, 1'b0, 3'b010, B_LAR | B_M | B_ABUS, 4'hA));
        tbl.push_back(fe("ld_w3", 4'h5, 1'b0, 1'b0, 1'b0, 3'b100, B_MBUS | B_DRW, 4'hF));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("jz_z1", 4'h8, 1'b0, 1'b1, 1'b0, 3'b010, B_PCADD, 4'hF));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("or_w2", 4'hA, 1'b0, 1'b0, 1'b0, 3'b010, B_DRW | B_LDZ | B_M | B_ABUS, 4'hE));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("ei_w2", 4'hF, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0, 4'hF));
        tbl.push_back(w1v(1'b1));
        tbl.push_back(fe("add_int_w2", 4'h1, 1'b0, 1'b0, 1'b1, 3'b010, B_DRW | B_LDZ | B_LDC | B_CIN | B_ABUS, 4'h9));
        tbl.push_back(mk("int_cycle", 3'b000, 4'h1, 1'b0, 1'b0, 1'b1, 3'b001, 1'b1, 16'h0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b1));
        tbl.push_back(w1v(1'b1));
        tbl.push_back(fe("nop_w2", 4'h0, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0, 4'hF));
        tbl.push_back(w1v(1'b1));
        tbl.push_back(fe("jmp_w2", 4'h9, 1'b0, 1'b0, 1'b0, 3'b010, B_M | B_ABUS | B_LPC, 4'hF));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("mov_w2", 4'hC, 1'b0, 1'b0, 1'b0, 3'b010, B_M | B_ABUS | B_DRW, 4'hA));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("out_w2", 4'hD, 1'b0, 1'b0, 1'b0, 3'b010, B_M | B_ABUS, 4'hA));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("and_w2", 4'h3, 1'b0, 1'b0, 1'b0, 3'b010, B_M | B_ABUS | B_DRW | B_LDZ, 4'hB));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("inc_w2", 4'h4, 1'b0, 1'b0, 1'b0, 3'b010, B_ABUS | B_DRW | B_LDZ | B_LDC, 4'h0));
        tbl.push_back(w1v(1'b0));
        tbl.push_back(fe("ei2_w2", 4'hF, 1'b0, 1'b0, 1'b1, 3'b010, 16'h0, 4'hF));
        tbl.push_back(w1v(1'b1));
        tbl.push_back(mk("stp_w2", 3'b000, 4'hE, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("halted", 3'b000, 4'hE, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 16'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));

        do_reset(3'b000);
        foreach (tbl[i]) apply(tbl[i]);

        // Write registers: RC walks and wraps; SW changes after latching are ignored
        do_reset(3'b100);
        apply(rstv(3'b100, 4'h0));
        for (int k = 0; k < 5; k++) begin
            logic [1:0] r;
            r = 2'(k);
            apply(mk("wreg_beat", (k < 3) ? 3'b100 : 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0,
                     B_SBUS | B_DRW | B_SELCTL, 1'b1, 4'hF, {r, r}, 1'b0, 1'b0));
        end

        // Read registers: pairs {RC, RC+1}, step 2
        do_reset(3'b011);
        apply(rstv(3'b011, 4'h0));
        apply(mk("rreg_0", 3'b011, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_SELCTL, 1'b1, 4'hF, 4'b0001, 1'b0, 1'b0));
        apply(mk("rreg_1", 3'b011, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_SELCTL, 1'b1, 4'hF, 4'b1011, 1'b0, 1'b0));
        apply(mk("rreg_2", 3'b011, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_SELCTL, 1'b1, 4'hF, 4'b0001, 1'b0, 1'b0));

        // Write memory
        do_reset(3'b001);
        apply(rstv(3'b001, 4'h0));
        apply(mk("wmem_addr", 3'b001, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_LAR | B_SBUS | B_SELCTL, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));
        apply(mk("wmem_data", 3'b001, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, B_SBUS | B_MEMW | B_ARINC | B_SELCTL, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));
        apply(mk("wmem_data", 3'b001, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, B_SBUS | B_MEMW | B_ARINC | B_SELCTL, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));

        // Read memory
        do_reset(3'b010);
        apply(rstv(3'b010, 4'h0));
        apply(mk("rmem_addr", 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_LAR | B_SBUS | B_SELCTL, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));
        apply(mk("rmem_data", 3'b010, 4'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, B_MBUS | B_ARINC | B_SELCTL, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0));

        // Asynchronous reset in the middle of LD W3
        do_reset(3'b000);
        apply(rstv(3'b000, 4'h0));
        apply(mk("fetch_st0", 3'b000, 4'h5, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_LPC | B_SBUS, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0));
        apply(fe("fetch_w1", 4'h5, 1'b0, 1'b0, 1'b0, 3'b001, B_LIR | B_PCINC, 4'hF));
        apply(fe("ld_w2", 4'h5, 1'b0, 1'b0, 1'b0, 3'b010, B_LAR | B_M | B_ABUS, 4'hA));
        IR = 4'h5;
        exp_q.push_back(fe("ld_w3_pre", 4'h5, 1'b0, 1'b0, 1'b0, 3'b100, B_MBUS | B_DRW, 4'hF));
        @(negedge T3);
        check_pop();
        #1 CLR = 1'b1;
        #1;
        exp_q.push_back(rstv(3'b000, 4'h5));
        check_pop();
        @(posedge T3);
        #1 CLR = 1'b0;
        apply(rstv(3'b000, 4'h5));
        apply(mk("refetch", 3'b000, 4'h5, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, B_LPC | B_SBUS, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hw_ctrl_seq.md
Name: hw_ctrl_seq

Overview:
- Next-generation hardwired controller for the teaching CPU.
- Unlike the previous controller, it owns its beat generator (W1..W3, ST0), latches the console mode, and sequences multi-register console transfers with an internal counter.
- Adds OR/CMP/MOV/OUT/EI instructions and a single-level interrupt handshake.
- Sits between the panel/IR and the datapath; every datapath strobe is derived here.

Parameters:
- RSEL_W, 2: register-select field width; register file has 2**RSEL_W registers; SEL is 2*RSEL_W bits wide.
- INT_EN, 1: 1 enables the interrupt logic and the EI opcode; 0 ties INTA/LVEC low and decodes 1111 as NOP.

Ports:
- T3 in 1: clock; all state updates on the rising edge.
- CLR in 1: reset; asynchronous, active-high.
- SW in 3: console mode (000 fetch/exec, 001 write mem, 010 read mem, 011 read reg, 100 write reg).
- IR in 4: opcode (IR[7:4]).
- C, Z in 1 each: ALU flags.
- INTR in 1: interrupt request, level.
- W out 3: one-hot beat {W3,W2,W1}.
- ST0 out 1: phase flag.
- DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC, CIN, M, MEMW, ABUS, SBUS, MBUS, SELCTL out 1 each: datapath strobes.
- STOP out 1: stop request to the panel clock.
- S out 4: ALU function.
- SEL out 2*RSEL_W: {dest, src} register select.
- INTA out 1: interrupt acknowledge.
- LVEC out 1: load PC with vector (datapath saves PC on the same beat).

Behaviour:
- Reset (CLR=1, async):
  - W=001, ST0=0, mode=SW-latch cleared, IEN=0, RC (register counter)=0, HALT=0, INTP=0.
  - All strobes 0; STOP=1; S=0000; SEL=0.
  - A reset mid-instruction abandons it with no write.
- Mode latch: SW is sampled on the first T3 edge after CLR falls and is held until the next reset. Later SW changes are ignored.
- Beat generator (advances each T3 unless HALT):
  - W1→W2, unless SHORT, in which case W1→W1.
  - W2→W3 if LONG, else W2→W1.
  - W3→W1.
  - SHORT and LONG are internal only.
- SELCTL = 1 in all console modes, 0 in fetch mode.
- STOP = 1 in every console mode, on STP, and during reset.
- Write mem (001), all beats SHORT:
  - ST0=0: LAR, SBUS; ST0<=1.
  - ST0=1: SBUS, MEMW, ARINC.
- Read mem (010), all beats SHORT:
  - ST0=0: LAR, SBUS; ST0<=1.
  - ST0=1: MBUS, ARINC.
- Write reg (100), SHORT:
  - Each beat: SBUS, DRW, SEL={RC,RC}; RC<=RC+1.
  - RC wraps modulo 2**RSEL_W.
- Read reg (011), SHORT:
  - Each beat: SEL={RC,RC+1 mod 2**RSEL_W}; RC<=RC+2 (wrap).
  - No write strobes.
- Fetch (000):
  - ST0=0, W1: LPC, SBUS, SHORT; ST0<=1.
  - ST0=1, W1: LIR, PCINC.
  - The instruction then executes in W2 (and W3 if LONG).
- Execute table, W2 unless stated; S/M/CIN given:
  - 0000 NOP: none.
  - 0001 ADD: S=1001, M=0, CIN=1; ABUS, DRW, LDZ, LDC.
  - 0010 SUB: S=0110, M=0, CIN=0; ABUS, DRW, LDZ, LDC.
  - 0011 AND: S=1011, M=1; ABUS, DRW, LDZ.
  - 0100 INC: S=0000, M=0, CIN=0; ABUS, DRW, LDZ, LDC.
  - 0101 LD: W2 S=1010, M, ABUS, LAR, LONG; W3 MBUS, DRW.
  - 0110 ST: W2 S=1111, M, ABUS, LAR, LONG; W3 S=1010, M, ABUS, MEMW.
  - 0111 JC: PCADD iff C=1.
  - 1000 JZ: PCADD iff Z=1.
  - 1001 JMP: S=1111, M, ABUS, LPC.
  - 1010 OR: S=1110, M=1; ABUS, DRW, LDZ.
  - 1011 CMP: S=0110, M=0, CIN=0; LDZ, LDC, no DRW.
  - 1100 MOV: S=1010, M; ABUS, DRW.
  - 1101 OUT: S=1010, M; ABUS.
  - 1110 STP: STOP=1 from W2; HALT<=1; W frozen until reset.
  - 1111 EI: IEN<=1 (NOP if INT_EN=0).
- S defaults to 1111 and CIN to 0 outside the listed beats.
- Interrupt request:
  - On the edge ending an instruction's last beat (W2 non-LONG, or W3) in fetch mode with ST0=1, INTP<=1 if INT_EN, IEN and INTR are all 1.
  - EI itself is excluded: an interrupt is taken no earlier than after the following instruction.
- Interrupt cycle (INTP=1):
  - Next W1 asserts INTA and LVEC, SHORT; LIR and PCINC are suppressed.
  - INTP<=0 and IEN<=0 on that edge; normal fetch follows.
- STP outranks a pending interrupt: HALT is set and INTP is cleared.

Test Plan:
- CLR pulse mid-LD W3 → W=001, ST0=0, DRW=0, STOP=1 immediately (async); no MEMW/DRW afterwards until a new fetch.
- SW=100, RSEL_W=2, 5 beats → DRW=1 each beat; SEL=00_00, 01_01, 10_10, 11_11, 00_00 (wrap).
- SW=000, IR=0110 after fetch → W2: LAR, ABUS, M, S=1111, LONG; W3: MEMW, S=1010; then W1 with LIR.
- IR=0111 with C=0, then C=1 → PCADD=0, then PCADD=1 in W2; W2→W1 (no W3).
- EI, then ADD with INTR=1 → ADD completes (DRW, CIN=1); next W1: INTA=LVEC=1, LIR=0; following W1: LIR=1; IEN=0, so a held INTR is not retaken.
- IR=1110 with INTR=1, IEN=1 → STOP=1 from W2; W frozen at 010 over 10 edges; INTA never asserted.
